// File: rtl/img_scan_ctrl.sv
// img_scan_ctrl: raster scan of one frame from memory into a ready/valid pixel stream.
// Ports: clk/rstn; start/abort/base_addr control; busy/done/frame_cnt status;
// mem_rd_en/mem_addr/mem_rd_data memory read port; pix_* downstream stream.
// Optional macro SCAN_STALL_CNT_EN adds stall_cnt[15:0] (backpressure cycles per frame).
module img_scan_ctrl #(
    parameter int IMG_WIDTH  = 220,
    parameter int IMG_HEIGHT = 220,
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 8,
    parameter int RD_LAT     = 2,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  start,
    input  logic                  abort,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    output logic                  busy,
    output logic                  done,
    output logic                  mem_rd_en,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    input  logic [DATA_WIDTH-1:0] mem_rd_data,
    output logic [DATA_WIDTH-1:0] pix_data,
    output logic                  pix_valid,
    input  logic                  pix_ready,
    output logic                  pix_sof,
    output logic                  pix_eol,
    output logic                  pix_eof,
`ifdef SCAN_STALL_CNT_EN
    output logic [15:0]           stall_cnt,
`endif
    output logic [7:0]            frame_cnt
);

    localparam int CW = $clog2(IMG_WIDTH);
    localparam int RW = $clog2(IMG_HEIGHT);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int NW = PW + 1;
    localparam int EW = DATA_WIDTH + 3;
    localparam logic [CW-1:0] COL_LAST = CW'(IMG_WIDTH - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMG_HEIGHT - 1);
    localparam logic [NW:0]   DEPTH    = (NW + 1)'(FIFO_DEPTH);

    typedef enum logic [2:0] {
        S_IDLE, S_SCAN, S_DRAIN, S_FLUSH, S_DONE
    } state_t;

    state_t                state;
    logic [ADDR_WIDTH-1:0] base_q;
    logic [ADDR_WIDTH-1:0] offset;
    logic [CW-1:0]         col;
    logic [RW-1:0]         row;
    logic                  iss_sof, iss_eol, iss_eof;
    logic [NW-1:0]         inflight;
    logic [NW-1:0]         fifo_cnt;
    logic [PW-1:0]         wr_ptr, rd_ptr;
    logic [RD_LAT-1:0]     pipe_v;
    logic [2:0]            pipe_t [RD_LAT];
    logic [EW-1:0]         fifo_mem [FIFO_DEPTH];

    logic last_px, pop, push, start_ok, kill, credit, issue;

    always_comb begin
        last_px  = (row == ROW_LAST) && (col == COL_LAST);
        pop      = pix_valid && pix_ready;
        start_ok = (state == S_IDLE) && start && !abort;
        kill     = abort && ((state == S_SCAN) || (state == S_DRAIN));
        // A pop this cycle frees its slot before the new read can land.
        credit   = ({1'b0, inflight} + {1'b0, fifo_cnt}
                    - (NW + 1)'(pop)) < DEPTH;
        issue    = start_ok || ((state == S_SCAN) && !abort && credit);
        // Reads returning during abort/flush are dropped.
        push     = pipe_v[RD_LAT-1] && (state != S_FLUSH) && !kill;
    end

    assign pix_valid = (fifo_cnt != '0);
    assign {pix_sof, pix_eol, pix_eof, pix_data} = fifo_mem[rd_ptr];

    // Tag pipe, in-flight credit and output FIFO.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            pipe_v   <= '0;
            inflight <= '0;
            fifo_cnt <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            for (int i = 0; i < RD_LAT; i++) pipe_t[i] <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) fifo_mem[i] <= '0;
        end else begin
            pipe_v[0] <= mem_rd_en;
            pipe_t[0] <= {iss_sof, iss_eol, iss_eof};
            for (int i = 1; i < RD_LAT; i++) begin
                pipe_v[i] <= pipe_v[i-1];
                pipe_t[i] <= pipe_t[i-1];
            end
            inflight <= inflight + NW'(issue) - NW'(pipe_v[RD_LAT-1]);
            if (kill) begin
                fifo_cnt <= '0;
                wr_ptr   <= '0;
                rd_ptr   <= '0;
            end else begin
                if (push) begin
                    fifo_mem[wr_ptr] <= {pipe_t[RD_LAT-1], mem_rd_data};
                    wr_ptr <= wr_ptr + 1'b1;
                end
                if (pop) rd_ptr <= rd_ptr + 1'b1;
                fifo_cnt <= fifo_cnt + NW'(push) - NW'(pop);
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state     <= S_IDLE;
            busy      <= 1'b0;
            done      <= 1'b0;
            mem_rd_en <= 1'b0;
            mem_addr  <= '0;
            base_q    <= '0;
            offset    <= '0;
            col       <= '0;
            row       <= '0;
            iss_sof   <= 1'b0;
            iss_eol   <= 1'b0;
            iss_eof   <= 1'b0;
            frame_cnt <= '0;
        end else begin
            mem_rd_en <= issue;
            done      <= 1'b0;
            unique case (state)
                S_IDLE: if (start_ok) begin
                    // First read goes out with the start acceptance.
                    base_q   <= base_addr;
                    mem_addr <= base_addr;
                    iss_sof  <= 1'b1;
                    iss_eol  <= 1'b0;
                    iss_eof  <= 1'b0;
                    offset   <= ADDR_WIDTH'(1);
                    col      <= CW'(1);
                    row      <= '0;
                    busy     <= 1'b1;
                    state    <= S_SCAN;
                end
                S_SCAN: begin
                    if (abort) begin
                        state <= S_FLUSH;
                    end else if (issue) begin
                        mem_addr <= base_q + offset;
                        iss_sof  <= (offset == '0);
                        iss_eol  <= (col == COL_LAST);
                        iss_eof  <= last_px;
                        offset   <= offset + 1'b1;
                        if (col == COL_LAST) begin
                            col <= '0;
                            row <= row + 1'b1;
                        end else begin
                            col <= col + 1'b1;
                        end
                        if (last_px) state <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    if (abort) begin
                        state <= S_FLUSH;
                    end else if (inflight == '0 && fifo_cnt == '0) begin
                        state     <= S_DONE;
                        done      <= 1'b1;
                        frame_cnt <= frame_cnt + 1'b1;
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                end
                S_FLUSH: if (inflight == '0) begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

`ifdef SCAN_STALL_CNT_EN
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            stall_cnt <= '0;
        end else if (start_ok) begin
            stall_cnt <= '0;
        end else if (pix_valid && !pix_ready && stall_cnt != 16'hFFFF
                     && (state == S_SCAN || state == S_DRAIN)) begin
            stall_cnt <= stall_cnt + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_img_scan_ctrl.sv
// Testbench for img_scan_ctrl: 4x3 frame, RD_LAT=2, FIFO_DEPTH=4.
// Reference model derives each pixel from base+index; memory returns addr[7:0]^key.
module tb_img_scan_ctrl;

    localparam int W    = 4;
    localparam int H    = 3;
    localparam int NPIX = W * H;
    localparam int LAT  = 2;

    logic        clk = 1'b0;
    logic        rstn, start, abort, pix_ready;
    logic [15:0] base_addr;
    logic        busy, done, mem_rd_en;
    logic [15:0] mem_addr;
    logic [7:0]  mem_rd_data, pix_data, frame_cnt;
    logic        pix_valid, pix_sof, pix_eol, pix_eof;
`ifdef SCAN_STALL_CNT_EN
    logic [15:0] stall_cnt;
`endif

    img_scan_ctrl #(
        .IMG_WIDTH(W), .IMG_HEIGHT(H), .ADDR_WIDTH(16),
        .DATA_WIDTH(8), .RD_LAT(LAT), .FIFO_DEPTH(4)
    ) dut (
        .clk(clk), .rstn(rstn), .start(start), .abort(abort),
        .base_addr(base_addr), .busy(busy), .done(done),
        .mem_rd_en(mem_rd_en), .mem_addr(mem_addr),
        .mem_rd_data(mem_rd_data), .pix_data(pix_data),
        .pix_valid(pix_valid), .pix_ready(pix_ready),
        .pix_sof(pix_sof), .pix_eol(pix_eol), .pix_eof(pix_eof),
`ifdef SCAN_STALL_CNT_EN
        .stall_cnt(stall_cnt),
`endif
        .frame_cnt(frame_cnt)
    );

    always #5 clk = ~clk;

    int          cyc = 0;
    int          total = 0;
    int          bad = 0;
    int          issue_idx, exp_idx, done_cnt, first_rd, last_rd;
    int          first_v, max_out;
    logic [15:0] fbase;
    logic [7:0]  key;
    logic [7:0]  exp_fc;
    bit          quiet, aborted, hold;
    logic [10:0] prev;
    logic [7:0]  rd_pipe [LAT];

    always @(posedge clk) cyc <= cyc + 1;

    // Frame memory with fixed read latency.
    always @(posedge clk) begin
        rd_pipe[0] <= mem_rd_en ? (mem_addr[7:0] ^ key) : 8'hEE;
        for (int i = 1; i < LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
    end
    assign mem_rd_data = rd_pipe[LAT-1];

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] outs();
        return 64'({busy, done, mem_rd_en, mem_addr, pix_data,
                    pix_valid, pix_sof, pix_eol, pix_eof, frame_cnt});
    endfunction

    // Stream monitor against the reference pixel sequence.
    always @(negedge clk) begin
        logic [15:0] a;
        logic [7:0]  ed;
        int          p;
        if (!rstn || quiet) begin
            hold = 1'b0;
        end else begin
            if (mem_rd_en) begin
                a = fbase + 16'(issue_idx);
                chk("rd_addr", 64'(mem_addr), 64'(a));
                if (first_rd < 0) first_rd = cyc;
                last_rd = cyc;
                issue_idx++;
            end
            if (!aborted && (issue_idx - exp_idx) > max_out)
                max_out = issue_idx - exp_idx;
            if (hold && !aborted)
                chk("hold", 64'({pix_valid, pix_sof, pix_eol, pix_eof,
                                 pix_data}), 64'({1'b1, prev}));
            if (pix_valid && first_v < 0) first_v = cyc;
            if (pix_valid && pix_ready) begin
                p = exp_idx;
                if (p >= NPIX) begin
                    chk("extra_pix", 64'(p), 64'(NPIX - 1));
                end else begin
                    a  = fbase + 16'(p);
                    ed = a[7:0] ^ key;
                    chk("pix", 64'({pix_sof, pix_eol, pix_eof, pix_data}),
                        64'({p == 0, (p % W) == W - 1, p == NPIX - 1, ed}));
                end
                exp_idx++;
            end
            if (done) done_cnt++;
            hold = pix_valid && !pix_ready;
            prev = {pix_sof, pix_eol, pix_eof, pix_data};
        end
    end

    task automatic setup(input logic [15:0] b, input logic [7:0] k);
        fbase = b;
        key = k;
        issue_idx = 0;
        exp_idx = 0;
        first_rd = -1;
        last_rd = -1;
        first_v = -1;
        max_out = 0;
        aborted = 1'b0;
    endtask

    // mode 0: ready=1, 1: 10-cycle stall, 2: random ready + stray starts
    task automatic run_frame(input logic [15:0] b, input int mode);
        int  n, t, done0;
        bit  ok;
        setup(b, (mode == 0) ? 8'h00 : 8'($urandom));
        done0 = done_cnt;
        ok = 1'b0;
        @(posedge clk); #1;
        start = 1'b1;
        base_addr = b;
        pix_ready = 1'b1;
        n = cyc;
        @(posedge clk); #1;
        start = 1'b0;
        base_addr = 16'($urandom);
        for (int i = 0; i < 400; i++) begin
            t = cyc - n;
            if (mode == 1) pix_ready = !(t >= 6 && t <= 15);
            if (mode == 2) begin
                pix_ready = ($urandom_range(0, 2) != 0);
                start = busy && ($urandom_range(0, 7) == 0);
            end
            @(posedge clk); #1;
            start = 1'b0;
            if (done_cnt != done0) begin
                ok = 1'b1;
                break;
            end
        end
        pix_ready = 1'b1;
        exp_fc = exp_fc + 8'd1;
        chk("frame_timeout", 64'(ok), 64'(1));
        @(negedge clk);
        chk("done_pulses", 64'(done_cnt - done0), 64'(1));
        chk("pix_count", 64'(exp_idx), 64'(NPIX));
        chk("rd_count", 64'(issue_idx), 64'(NPIX));
        chk("credit_max", 64'(max_out <= 4), 64'(1));
        chk("busy_after", 64'(busy), 64'(0));
        chk("frame_cnt", 64'(frame_cnt), 64'(exp_fc));
        if (mode == 0) begin
            chk("lat_rd", 64'(first_rd - n), 64'(1));
            chk("lat_valid", 64'(first_v - n), 64'(2 + LAT));
            chk("rd_burst", 64'(last_rd - first_rd), 64'(NPIX - 1));
        end
`ifdef SCAN_STALL_CNT_EN
        if (mode == 0) chk("stall_cnt0", 64'(stall_cnt), 64'(0));
        if (mode == 1) chk("stall_cnt", 64'(stall_cnt), 64'(10));
`endif
    endtask

    task automatic abort_frame(input logic [15:0] b);
        int done0, rd, fell;
        bit ok;
        setup(b, 8'($urandom));
        done0 = done_cnt;
        ok = 1'b0;
        @(posedge clk); #1;
        start = 1'b1;
        base_addr = b;
        pix_ready = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (exp_idx >= 5) begin
                ok = 1'b1;
                break;
            end
            @(posedge clk); #1;
        end
        chk("abort_reach", 64'(ok), 64'(1));
        abort = 1'b1;
        aborted = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        @(negedge clk);
        chk("abort_valid", 64'(pix_valid), 64'(0));
        rd = 0;
        fell = 0;
        for (int i = 0; i < 10; i++) begin
            if (mem_rd_en) rd++;
            if (!busy) fell = 1;
            @(negedge clk);
        end
        chk("abort_rd", 64'(rd), 64'(0));
        chk("abort_busy", 64'(fell), 64'(1));
        chk("abort_done", 64'(done_cnt - done0), 64'(0));
        chk("abort_fcnt", 64'(frame_cnt), 64'(exp_fc));
        aborted = 1'b0;
    endtask

    initial begin
        int  hits;
        bit  ok;
        rstn = 1'b0;
        start = 1'b0;
        abort = 1'b0;
        pix_ready = 1'b1;
        base_addr = 16'h0;
        quiet = 1'b0;
        done_cnt = 0;
        exp_fc = 8'd0;
        setup(16'h0, 8'h0);
        #7;
        chk("reset_outs", outs(), 64'(0));
`ifdef SCAN_STALL_CNT_EN
        chk("reset_stall", 64'(stall_cnt), 64'(0));
`endif
        repeat (2) @(posedge clk);
        @(negedge clk);
        rstn = 1'b1;

        run_frame(16'h0100, 0);
        run_frame(16'h0100, 1);
        abort_frame(16'h0200);
        run_frame(16'h0300, 0);

        // start together with abort in IDLE must be ignored
        @(posedge clk); #1;
        start = 1'b1;
        abort = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        abort = 1'b0;
        hits = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (busy || mem_rd_en) hits++;
        end
        chk("idle_start_abort", 64'(hits), 64'(0));

        run_frame(16'hFFFA, 0);
        for (int i = 0; i < 6; i++) run_frame(16'($urandom), 2);

        // reset in the middle of a scan
        setup(16'h0400, 8'h5A);
        @(posedge clk); #1;
        start = 1'b1;
        base_addr = 16'h0400;
        @(posedge clk); #1;
        start = 1'b0;
        ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (issue_idx >= 6) begin
                ok = 1'b1;
                break;
            end
            @(posedge clk); #1;
        end
        chk("rst_reach", 64'(ok), 64'(1));
        quiet = 1'b1;
        rstn = 1'b0;
        #1;
        chk("rst_mid_outs", outs(), 64'(0));
        exp_fc = 8'd0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rstn = 1'b1;
        quiet = 1'b0;
        run_frame(16'h0100, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
